// File: rtl/alu_exec_stage.sv
// Two-stage pipelined EX-stage ALU with valid/ready handshakes on both sides.
// Optional NOR (op 1100) is enabled by defining ALU_EXEC_NOR_EN.
module alu_exec_stage #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef ALU_EXEC_NOR_EN
  localparam logic [3:0] OP_NOR = 4'b1100;
`endif

  logic             r_s1_v;
  logic [3:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_v;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic [TAG_W-1:0] r_tag;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic             w_lt;
  logic [WIDTH-1:0] w_res;
  logic             w_ill;
  logic             w_zero;

  // S2 frees up whenever it is empty or its result is being taken this cycle.
  assign w_s2_adv = !r_s2_v || out_ready;
  assign w_s1_adv = !r_s1_v || w_s2_adv;
  assign in_ready = w_s1_adv;

  assign w_lt = $signed(r_s1_a) < $signed(r_s1_b);

  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    case (r_s1_op)
      OP_AND:  w_res = r_s1_a & r_s1_b;
      OP_OR:   w_res = r_s1_a | r_s1_b;
      OP_ADD:  w_res = r_s1_a + r_s1_b;
      OP_SUB:  w_res = r_s1_a - r_s1_b;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
`ifdef ALU_EXEC_NOR_EN
      OP_NOR:  w_res = ~(r_s1_a | r_s1_b);
`endif
      default: w_ill = 1'b1;
    endcase
    w_zero = (w_res == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_s1_op  <= '0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_tag <= '0;
    end else if (w_s1_adv) begin
      r_s1_v   <= in_valid;
      r_s1_op  <= operation;
      r_s1_a   <= a;
      r_s1_b   <= b;
      r_s1_tag <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v    <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
      r_tag     <= '0;
    end else if (w_s2_adv) begin
      r_s2_v    <= r_s1_v;
      r_result  <= w_res;
      r_zero    <= w_zero;
      r_illegal <= w_ill;
      r_tag     <= r_s1_tag;
    end
  end

  assign out_valid = r_s2_v;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;
  assign out_tag   = r_tag;

endmodule
